rr_mux_arbiter: RTL

Parametrised, registered N-way, W-bit multiplexer with valid/ready handshake on every input channel and on the output. Picks one requesting channel per cycle using round-robin or fixed priority, forwards its word through one output register, and reports which channel was picked. It generalises the CPU's 4-way 16-bit combinational mux into a flow-controlled merge point for multiple producers, such as memory-mapped I/O sources feeding one consumer.

---
 rtl/rr_mux_arbiter_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/rr_mux_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int PRIORITY_RR    = 0;
  localparam int PRIORITY_FIXED = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// One-hot grant picker: round-robin from ptr, or lowest index first.
module rr_priority_picker
  import rr_mux_arbiter_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SEL_W         = 2,
  parameter int PRIORITY_MODE = PRIORITY_RR
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0]      base;
  logic [2*CHANNELS-1:0] req_dbl;
  logic [2*CHANNELS-1:0] gnt_dbl;
  logic [CHANNELS-1:0]   rot;
  logic [CHANNELS-1:0]   rot_first;

  assign base = (PRIORITY_MODE == PRIORITY_FIXED) ? '0 : ptr;

  // Rotate so the search starts at bit 0, isolate the lowest set bit, rotate back.
  assign req_dbl   = {req, req};
  assign rot       = CHANNELS'(req_dbl >> base);
  assign rot_first = rot & (~rot + CHANNELS'(1));
  assign gnt_dbl   = {{CHANNELS{1'b0}}, rot_first} << base;
  assign grant     = gnt_dbl[CHANNELS-1:0] | gnt_dbl[2*CHANNELS-1:CHANNELS];

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) grant_idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Registered N-way merge point: valid/ready on each input and on the output,
// one word per cycle, out_sel reports which channel supplied out_data.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 4,
  parameter int SEL_W         = 2,
  parameter int PRIORITY_MODE = PRIORITY_RR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  if (SEL_W != clog2(CHANNELS)) begin : g_bad_sel_w
    $error("rr_mux_arbiter: SEL_W must equal clog2(CHANNELS)");
  end
  if (CHANNELS < 2) begin : g_bad_channels
    $error("rr_mux_arbiter: CHANNELS must be at least 2");
  end

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    ptr_next;
  logic [WIDTH-1:0]    grant_data;
  logic                can_load;
  logic                take;

  rr_priority_picker #(
    .CHANNELS      (CHANNELS),
    .SEL_W         (SEL_W),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_picker (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_load = ~out_valid | out_ready;
  assign in_ready = grant & {CHANNELS{can_load & ~reset}};
  assign take     = |(in_valid & in_ready);
  assign ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
      rr_ptr    <= ptr_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
